// File: rtl/multi_arrival_tracker.sv
// rtl/multi_arrival_tracker.sv - N-channel arrival tracker with first-arrival capture and timeout
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   req[N]       per-channel arrival requests
//   clear        synchronous return to IDLE; first_idx is kept
//   seen[N]      sticky record of channels that have arrived
//   first_idx    index of the first-arriving channel (lowest index on a tie)
//   first_valid  first_idx holds a captured value
//   all_seen     every channel has arrived (DONE)
//   timeout      COLLECT ran too long (TIMED_OUT)
//   idle_quiet   the tracker was in IDLE with req==0 at the last edge
module multi_arrival_tracker #(
    parameter  int N              = 2,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int IDX_RAW        = $clog2(N),
    localparam int IDX_W          = (IDX_RAW < 1) ? 1 : IDX_RAW,
    localparam int CNT_RAW        = $clog2(TIMEOUT_CYCLES + 1),
    localparam int CNT_W          = (CNT_RAW < 1) ? 1 : CNT_RAW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             clear,
    output logic [N-1:0]     seen,
    output logic [IDX_W-1:0] first_idx,
    output logic             first_valid,
    output logic             all_seen,
    output logic             timeout,
    output logic             idle_quiet
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COLLECT   = 2'd1,
        S_DONE      = 2'd2,
        S_TIMED_OUT = 2'd3
    } state_t;

    localparam logic [N-1:0]     ALL_ONES   = '1;
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Last counter value spent in COLLECT; only meaningful when TIMEOUT_EN.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [IDX_W-1:0] low_idx;
    logic [N-1:0]     merged;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign merged = seen | req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            seen        <= '0;
            first_idx   <= '0;
            first_valid <= 1'b0;
            all_seen    <= 1'b0;
            timeout     <= 1'b0;
            idle_quiet  <= 1'b0;
            counter     <= '0;
        end else if (clear) begin
            state       <= S_IDLE;
            seen        <= '0;
            first_valid <= 1'b0;
            all_seen    <= 1'b0;
            timeout     <= 1'b0;
            idle_quiet  <= 1'b0;
            counter     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req == '0) begin
                        idle_quiet <= 1'b1;
                    end else begin
                        seen        <= req;
                        first_idx   <= low_idx;
                        first_valid <= 1'b1;
                        idle_quiet  <= 1'b0;
                        counter     <= '0;
                        if (req == ALL_ONES) begin
                            state    <= S_DONE;
                            all_seen <= 1'b1;
                        end else begin
                            state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    seen <= merged;
                    // Completion is tested first so it beats a timeout on the same edge.
                    if (merged == ALL_ONES) begin
                        state    <= S_DONE;
                        all_seen <= 1'b1;
                    end else if (TIMEOUT_EN && (counter == CNT_LAST)) begin
                        state   <= S_TIMED_OUT;
                        timeout <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                S_DONE, S_TIMED_OUT: begin
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_arrival_tracker.sv
// tb/tb_multi_arrival_tracker.sv - directed vector bench for multi_arrival_tracker
module tb_multi_arrival_tracker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // u2: N=2 TO=16, u4: N=4 TO=16, u4t: N=4 TO=5, u2t: N=2 TO=3, u1: N=1 TO=16
    logic [1:0] req2 = '0, req2t = '0;
    logic [3:0] req4 = '0, req4t = '0;
    logic [0:0] req1 = '0;
    logic clr2 = 0, clr4 = 0, clr4t = 0, clr2t = 0, clr1 = 0;

    logic [1:0] seen2, seen2t;
    logic [3:0] seen4, seen4t;
    logic [0:0] seen1;
    logic [0:0] fidx2, fidx2t, fidx1;
    logic [1:0] fidx4, fidx4t;
    logic fv2, all2, to2, iq2;
    logic fv4, all4, to4, iq4;
    logic fv4t, all4t, to4t, iq4t;
    logic fv2t, all2t, to2t, iq2t;
    logic fv1, all1, to1, iq1;

    multi_arrival_tracker #(.N(2), .TIMEOUT_CYCLES(16)) u2 (
        .clk(clk), .rst(rst), .req(req2), .clear(clr2), .seen(seen2), .first_idx(fidx2),
        .first_valid(fv2), .all_seen(all2), .timeout(to2), .idle_quiet(iq2));
    multi_arrival_tracker #(.N(4), .TIMEOUT_CYCLES(16)) u4 (
        .clk(clk), .rst(rst), .req(req4), .clear(clr4), .seen(seen4), .first_idx(fidx4),
        .first_valid(fv4), .all_seen(all4), .timeout(to4), .idle_quiet(iq4));
    multi_arrival_tracker #(.N(4), .TIMEOUT_CYCLES(5)) u4t (
        .clk(clk), .rst(rst), .req(req4t), .clear(clr4t), .seen(seen4t), .first_idx(fidx4t),
        .first_valid(fv4t), .all_seen(all4t), .timeout(to4t), .idle_quiet(iq4t));
    multi_arrival_tracker #(.N(2), .TIMEOUT_CYCLES(3)) u2t (
        .clk(clk), .rst(rst), .req(req2t), .clear(clr2t), .seen(seen2t), .first_idx(fidx2t),
        .first_valid(fv2t), .all_seen(all2t), .timeout(to2t), .idle_quiet(iq2t));
    multi_arrival_tracker #(.N(1), .TIMEOUT_CYCLES(16)) u1 (
        .clk(clk), .rst(rst), .req(req1), .clear(clr1), .seen(seen1), .first_idx(fidx1),
        .first_valid(fv1), .all_seen(all1), .timeout(to1), .idle_quiet(iq1));

    typedef struct {
        logic [3:0] req;
        logic       clr;
        logic [3:0] seen;
        logic [1:0] fidx;
        logic       fv;
        logic       all;
        logic       to;
        logic       iq;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl[NV];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check4t(input string tag, input logic [3:0] s, input logic [1:0] fi,
                           input logic fv, input logic al, input logic to, input logic iq);
        check({tag, "_seen"}, 32'(seen4t), 32'(s));
        check({tag, "_fidx"}, 32'(fidx4t), 32'(fi));
        check({tag, "_fv"}, 32'(fv4t), 32'(fv));
        check({tag, "_all"}, 32'(all4t), 32'(al));
        check({tag, "_to"}, 32'(to4t), 32'(to));
        check({tag, "_iq"}, 32'(iq4t), 32'(iq));
    endtask

    initial begin
        //            req      clr   seen     fidx   fv    all   to    iq
        tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4'b0001, 1'b0, 4'b0101, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{4'b1010, 1'b0, 4'b1111, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{4'b0000, 1'b0, 4'b1111, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{4'b0011, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{4'b1111, 1'b0, 4'b1111, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{4'b0000, 1'b0, 4'b1111, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{4'b0110, 1'b0, 4'b0110, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{4'b0111, 1'b0, 4'b1111, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_seen4", 32'(seen4), 32'd0);
        check("rst_fv4", 32'(fv4), 32'd0);
        check("rst_iq4", 32'(iq4), 32'd0);
        check("rst_all2", 32'(all2), 32'd0);
        check("rst_to4t", 32'(to4t), 32'd0);
        #5 rst = 1'b0;

        // Test 1: N=2 basic sequence
        req2 = 2'b00; tick;
        check("t1_iq", 32'(iq2), 32'd1);
        check("t1_seen0", 32'(seen2), 32'd0);
        tick;
        req2 = 2'b01; tick;
        check("t1_seen1", 32'(seen2), 32'b01);
        check("t1_fidx1", 32'(fidx2), 32'd0);
        check("t1_fv1", 32'(fv2), 32'd1);
        check("t1_all1", 32'(all2), 32'd0);
        check("t1_iq1", 32'(iq2), 32'd0);
        req2 = 2'b10; tick;
        check("t1_seen2", 32'(seen2), 32'b11);
        check("t1_all2", 32'(all2), 32'd1);
        check("t1_to2", 32'(to2), 32'd0);
        req2 = 2'b00;

        // Tests 2/3 plus tie-break and clear behaviour: table on u4
        for (int i = 0; i < NV; i++) begin
            req4 = tbl[i].req;
            clr4 = tbl[i].clr;
            tick;
            check($sformatf("v%0d_seen", i), 32'(seen4), 32'(tbl[i].seen));
            check($sformatf("v%0d_fidx", i), 32'(fidx4), 32'(tbl[i].fidx));
            check($sformatf("v%0d_fv", i), 32'(fv4), 32'(tbl[i].fv));
            check($sformatf("v%0d_all", i), 32'(all4), 32'(tbl[i].all));
            check($sformatf("v%0d_to", i), 32'(to4), 32'(tbl[i].to));
            check($sformatf("v%0d_iq", i), 32'(iq4), 32'(tbl[i].iq));
        end
        req4 = '0; clr4 = 0;

        // Test 4: timeout on the 5th edge after capture (TO=5)
        req4t = 4'b0001; tick;
        check4t("t4_cap", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        req4t = 4'b0000;
        for (int k = 1; k <= 4; k++) tick;
        check("t4_edge4_to", 32'(to4t), 32'd0);
        tick;
        check4t("t4_edge5", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        req4t = 4'b1110; tick;
        check4t("t4_frozen", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        req4t = 4'b0000;

        // Test 5: completion beats timeout on the counter==2 edge (TO=3)
        req2t = 2'b01; tick;
        req2t = 2'b00; tick; tick;
        check("t5_to_pre", 32'(to2t), 32'd0);
        req2t = 2'b10; tick;
        check("t5_all", 32'(all2t), 32'd1);
        check("t5_to", 32'(to2t), 32'd0);
        // Same timing without completion does time out
        req2t = 2'b00; clr2t = 1; tick;
        clr2t = 0; req2t = 2'b01; tick;
        req2t = 2'b00; tick; tick;
        check("t5b_to_pre", 32'(to2t), 32'd0);
        tick;
        check("t5b_to", 32'(to2t), 32'd1);
        check("t5b_all", 32'(all2t), 32'd0);

        // N=1: any req goes straight to DONE
        tick;
        check("n1_iq", 32'(iq1), 32'd1);
        req1 = 1'b1; tick;
        check("n1_all", 32'(all1), 32'd1);
        check("n1_seen", 32'(seen1), 32'd1);
        check("n1_to", 32'(to1), 32'd0);
        req1 = 1'b0;

        // Test 6: clear with req in COLLECT, then async reset mid-COLLECT
        clr4t = 1; tick;
        clr4t = 0; req4t = 4'b0001; tick;
        check4t("t6_col", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        clr4t = 1; req4t = 4'b0011; tick;
        check4t("t6_clr", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        clr4t = 0; req4t = 4'b0000; tick;
        check("t6_idle", 32'(iq4t), 32'd1);
        req4t = 4'b0010; tick;
        check4t("t6_col2", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check4t("t6_rst", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_rst_all2", 32'(all2), 32'd0);
        #2 rst = 1'b0;
        req4t = 4'b0000; tick;
        check("t6_post_iq", 32'(iq4t), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
